// File: rtl/fpsub_seq.sv
// fpsub_seq: iterative binary32 subtractor, result = a - b, valid/ready on both sides.
// Optional FPSUB_SEQ_FLAGS_EN adds flags[2:0] = {overflow, underflow, zero}.
module fpsub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
`ifdef FPSUB_SEQ_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, EXEC, NORM, DONE
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_a, r_b, r_result;
  logic        r_sx, r_sy, r_s;
  logic [24:0] r_mx, r_my, r_m;
  logic [7:0]  r_e;
  logic [4:0]  r_cnt;
`ifdef FPSUB_SEQ_FLAGS_EN
  logic [2:0]  r_flags;
`endif

  logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_diff, w_einc;
  logic [24:0] w_ma, w_mb, w_mx, w_my, w_m;
  logic        w_sb, w_swap, w_sx, w_sy, w_s;
  logic        w_same, w_ge;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
`ifdef FPSUB_SEQ_FLAGS_EN
  assign flags     = r_flags;
`endif

  // unpack and order operands; b's sign is flipped so the core adds
  assign w_ea   = r_a[30:23];
  assign w_eb   = r_b[30:23];
  assign w_ma   = {1'b0, w_ea != 8'd0, r_a[22:0]};
  assign w_mb   = {1'b0, w_eb != 8'd0, r_b[22:0]};
  assign w_sb   = ~r_b[31];
  assign w_swap = (w_eb > w_ea);
  assign w_ex   = w_swap ? w_eb : w_ea;
  assign w_ey   = w_swap ? w_ea : w_eb;
  assign w_mx   = w_swap ? w_mb : w_ma;
  assign w_my   = w_swap ? w_ma : w_mb;
  assign w_sx   = w_swap ? w_sb : r_a[31];
  assign w_sy   = w_swap ? r_a[31] : w_sb;
  assign w_diff = w_ex - w_ey;

  // signed-magnitude add of the aligned mantissas
  assign w_same = (r_sx == r_sy);
  assign w_ge   = (r_mx >= r_my);
  assign w_m    = w_same ? r_mx + r_my :
                  w_ge   ? r_mx - r_my : r_my - r_mx;
  assign w_s    = (w_same || w_ge) ? r_sx : r_sy;
  assign w_einc = r_e + 8'd1;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (in_valid) w_next = UNPACK;
      UNPACK: w_next = ALIGN;
      ALIGN:  if (r_cnt == 5'd0) w_next = EXEC;
      EXEC: begin
        if (w_m == 25'd0)                      w_next = DONE;
        else if (w_m[24] && w_einc == 8'hFF)   w_next = DONE;
        else                                   w_next = NORM;
      end
      NORM:   if (r_m[23] || r_e == 8'd1) w_next = DONE;
      DONE:   if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // datapath: one align or normalise step per cycle, truncating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sx     <= 1'b0;
      r_sy     <= 1'b0;
      r_s      <= 1'b0;
      r_mx     <= '0;
      r_my     <= '0;
      r_m      <= '0;
      r_e      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
`ifdef FPSUB_SEQ_FLAGS_EN
      r_flags  <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= b;
          end
        end
        UNPACK: begin
          r_sx <= w_sx;
          r_sy <= w_sy;
          r_mx <= w_mx;
          r_e  <= w_ex;
          if (w_diff > 8'd24) begin
            r_my  <= '0;
            r_cnt <= '0;
          end else begin
            r_my  <= w_my;
            r_cnt <= w_diff[4:0];
          end
        end
        ALIGN: begin
          if (r_cnt != 5'd0) begin
            r_my  <= r_my >> 1;
            r_cnt <= r_cnt - 5'd1;
          end
        end
        EXEC: begin
          r_s <= w_s;
          if (w_m == 25'd0) begin
            r_result <= 32'h0000_0000;
`ifdef FPSUB_SEQ_FLAGS_EN
            r_flags  <= 3'b001;
`endif
          end else if (w_m[24]) begin
            r_m <= w_m >> 1;
            r_e <= w_einc;
            if (w_einc == 8'hFF) begin
              r_result <= {w_s, 8'hFF, 23'd0};
`ifdef FPSUB_SEQ_FLAGS_EN
              r_flags  <= 3'b100;
`endif
            end
          end else begin
            r_m <= w_m;
          end
        end
        NORM: begin
          if (r_m[23]) begin
            r_result <= {r_s, r_e, r_m[22:0]};
`ifdef FPSUB_SEQ_FLAGS_EN
            r_flags  <= 3'b000;
`endif
          end else if (r_e == 8'd1) begin
            r_result <= 32'h0000_0000;
`ifdef FPSUB_SEQ_FLAGS_EN
            r_flags  <= 3'b010;
`endif
          end else begin
            r_m <= r_m << 1;
            r_e <= r_e - 8'd1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpsub_seq.sv
// tb_fpsub_seq: directed vectors with hand-computed results and latencies.
// Flag checks are active when FPSUB_SEQ_FLAGS_EN is defined.
module tb_fpsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;
`ifdef FPSUB_SEQ_FLAGS_EN
  logic [2:0]  flags;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fpsub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FPSUB_SEQ_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                     input string tag);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // issue one op, measure edges to out_valid, hold, then pop
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] er, input int el,
                        input logic [2:0] ef, input int hold,
                        input string tag);
    int n;
    @(negedge clk);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(n, el, {tag, " latency"});
    chk(result, er, {tag, " result"});
`ifdef FPSUB_SEQ_FLAGS_EN
    chk({29'd0, flags}, {29'd0, ef}, {tag, " flags"});
`else
    if (ef != ef) $display("unused");
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk(result, er, {tag, " held result"});
      chk({31'd0, out_valid}, 32'd1, {tag, " held out_valid"});
      chk({31'd0, in_ready}, 32'd0, {tag, " held in_ready"});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({31'd0, out_valid}, 32'd0, {tag, " popped"});
    chk({31'd0, in_ready}, 32'd1, {tag, " ready again"});
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a = '0;
    b = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk(result, 32'h0, "reset result");
    chk({31'd0, out_valid}, 32'd0, "reset out_valid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({31'd0, in_ready}, 32'd1, "reset in_ready");

    run_op(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 5, 3'b000, 0, "3-1");
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3, 3'b001, 0, "1-1");
    out_ready = 1'b1;
    run_op(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4, 3'b000, 0, "1+1");
    run_op(32'h3F80_0000, 32'h3F80_0001, 32'hB400_0000, 27, 3'b000, 0, "ulp");
    run_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 3, 3'b100, 0, "ovf");
    run_op(32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 4, 3'b010, 0, "unf");
    run_op(32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 4, 3'b000, 5, "clamp");

    @(negedge clk);
    a = 32'h3F80_0000;
    b = 32'h3580_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({31'd0, out_valid}, 32'd0, "rst out_valid");
    chk(result, 32'h0, "rst result");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({31'd0, in_ready}, 32'd1, "release in_ready");
    @(posedge clk);
    #1;
    chk({31'd0, in_ready}, 32'd1, "post in_ready");
    chk({31'd0, out_valid}, 32'd0, "post out_valid");

    run_op(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 3, 3'b001, 0, "0-0");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
